// File: rtl/pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_pkg: op encoding, default sizes and clog2 helper for the PC block.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pc_pkg;

  localparam int PC_ADDR_W_DEF      = 8;
  localparam int PC_STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_BRANCH
  } pc_op_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_return_stack: LIFO of return addresses with a registered top entry.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int W     = PC_ADDR_W_DEF,
  parameter int DEPTH = PC_STACK_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_din,
  output logic [W-1:0]          o_tos,
  output logic [clog2(DEPTH):0] o_sp,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int IDX_W = clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [IDX_W:0]   r_sp;
  logic [W-1:0]     r_tos;
  logic [IDX_W:0]   w_sp_m2;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_below_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_sp == (IDX_W+1)'(DEPTH));
  assign o_empty     = (r_sp == '0);
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !i_push && !o_empty;
  assign w_wr_idx    = r_sp[IDX_W-1:0];
  assign w_sp_m2     = r_sp - (IDX_W+1)'(2);
  assign w_below_idx = w_sp_m2[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  // r_tos shadows the top entry so a pop can reload the PC in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_tos <= '0;
    end else if (w_do_push) begin
      r_tos <= i_din;
      r_sp  <= r_sp + (IDX_W+1)'(1);
    end else if (w_do_pop) begin
      r_tos <= r_mem[w_below_idx];
      r_sp  <= r_sp - (IDX_W+1)'(1);
    end
  end

  assign o_tos = r_tos;
  assign o_sp  = r_sp;

endmodule
`default_nettype wire

// File: rtl/program_counter_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_counter_stack: PC with load/inc/call/ret and a hardware return   |
// | stack. Optional PC_REL_BRANCH_EN adds relative branch. Rev 1.0           |
// +--------------------------------------------------------------------------+
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W_DEF,
  parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF,
  parameter int STRIDE      = 1,
  parameter int RESET_VEC   = 0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        en,
  input  logic                        load,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        OE,
`ifdef PC_REL_BRANCH_EN
  input  logic                        branch,
  input  logic [ADDR_W-1:0]           offset,
`endif
  input  logic [ADDR_W-1:0]           PC_in,
  output logic [ADDR_W-1:0]           PC_out,
  output logic [ADDR_W-1:0]           count,
  output logic [clog2(STACK_DEPTH):0] sp,
  output logic                        ovf,
  output logic                        unf,
  output logic                        on
);

  localparam logic [ADDR_W-1:0] c_stride    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] c_reset_vec = ADDR_W'(RESET_VEC);

  pc_op_e            w_op;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_tos;
  logic              r_ovf;
  logic              r_unf;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic              w_full;
  logic              w_empty;

  assign w_inc = r_count + c_stride;

  always_comb begin
    w_op = PC_HOLD;
    if (load)      w_op = PC_LOAD;
    else if (call) w_op = PC_CALL;
    else if (ret)  w_op = PC_RET;
`ifdef PC_REL_BRANCH_EN
    else if (branch) w_op = PC_BRANCH;
`endif
    else if (en)   w_op = PC_INC;
  end

  // A call on a full stack still jumps; only the push is suppressed.
  always_comb begin
    w_next    = r_count;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (w_op)
      PC_INC:  w_next = w_inc;
      PC_LOAD: w_next = PC_in;
      PC_CALL: begin
        w_next    = PC_in;
        w_push    = !w_full;
        w_set_ovf = w_full;
      end
      PC_RET: begin
        if (!w_empty) begin
          w_next = w_tos;
          w_pop  = 1'b1;
        end else begin
          w_set_unf = 1'b1;
        end
      end
`ifdef PC_REL_BRANCH_EN
      PC_BRANCH: w_next = r_count + offset;
`endif
      default: w_next = r_count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= c_reset_vec;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  pc_return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_inc),
    .o_tos   (w_tos),
    .o_sp    (sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign count  = r_count;
  assign PC_out = OE ? r_count : '0;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign on     = en;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_program_counter_stack: directed vector bench for program_counter_stack|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_program_counter_stack;

  logic       clk;
  logic       RESET, en, load, call, ret, OE;
  logic [7:0] PC_in;
  logic [7:0] PC_out, count, PC_out2, count2;
  logic [2:0] sp, sp2;
  logic       ovf, unf, on, ovf2, unf2, on2;
`ifdef PC_REL_BRANCH_EN
  logic       branch;
  logic [7:0] offset;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst, en, load, call, ret, oe;
    logic [7:0] pc_in;
    logic [7:0] e_count;
    logic [2:0] e_sp;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  program_counter_stack #(.ADDR_W(8), .STACK_DEPTH(4), .STRIDE(1), .RESET_VEC(0)) dut (
    .CLK(clk), .RESET(RESET), .en(en), .load(load), .call(call), .ret(ret), .OE(OE),
`ifdef PC_REL_BRANCH_EN
    .branch(branch), .offset(offset),
`endif
    .PC_in(PC_in), .PC_out(PC_out), .count(count), .sp(sp), .ovf(ovf), .unf(unf), .on(on)
  );

  program_counter_stack #(.ADDR_W(8), .STACK_DEPTH(4), .STRIDE(2), .RESET_VEC(0)) dut2 (
    .CLK(clk), .RESET(RESET), .en(en), .load(load), .call(call), .ret(ret), .OE(OE),
`ifdef PC_REL_BRANCH_EN
    .branch(branch), .offset(offset),
`endif
    .PC_in(PC_in), .PC_out(PC_out2), .count(count2), .sp(sp2), .ovf(ovf2), .unf(unf2), .on(on2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, e, l, c, rt, o, input logic [7:0] pin,
                              input logic [7:0] ec, input logic [2:0] es,
                              input logic eo, eu);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.call = c; v.ret = rt; v.oe = o;
    v.pc_in = pin; v.e_count = ec; v.e_sp = es; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic drive(input logic r, e, l, c, rt, o, input logic [7:0] pin);
    @(negedge clk);
    RESET = r; en = e; load = l; call = c; ret = rt; OE = o; PC_in = pin;
`ifdef PC_REL_BRANCH_EN
    branch = 1'b0; offset = 8'h00;
`endif
  endtask

  initial begin
    RESET = 0; en = 0; load = 0; call = 0; ret = 0; OE = 0; PC_in = 8'h00;
`ifdef PC_REL_BRANCH_EN
    branch = 0; offset = 8'h00;
`endif
    //              rst en ld cl rt oe  pc_in  count  sp  ovf unf
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h04, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 8'h40, 8'h40, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h11, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h12, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 8'h33, 8'h33, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h81, 8'h81, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h82, 8'h82, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h83, 8'h83, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 8'h84, 8'h84, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h83, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h82, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h81, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h00, 8'h21, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h21, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h50, 8'h50, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'h60, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h10, 8'h10, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].call, vecs[i].ret,
            vecs[i].oe, vecs[i].pc_in);
      #1;
      chk($sformatf("v%0d on", i), 32'(on), 32'(vecs[i].en));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d sp", i), 32'(sp), 32'(vecs[i].e_sp));
      chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d unf", i), 32'(unf), 32'(vecs[i].e_unf));
      chk($sformatf("v%0d PC_out", i), 32'(PC_out),
          32'(vecs[i].oe ? vecs[i].e_count : 8'h00));
    end

    // STRIDE=2 instance: wrap of PC+STRIDE and of the pushed return address.
    drive(1, 0, 0, 0, 0, 0, 8'h00); @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0, 8'hFE); @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 1, 8'h00); @(posedge clk); #1;
    chk("s2 wrap count", 32'(count2), 32'h00);
    chk("s2 wrap PC_out", 32'(PC_out2), 32'h00);
    chk("s2 wrap ovf", 32'(ovf2), 32'h0);
    chk("s2 wrap unf", 32'(unf2), 32'h0);
    chk("s1 count", 32'(count), 32'hFF);
    drive(0, 0, 1, 0, 0, 0, 8'hFE); @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 1, 8'h40); @(posedge clk); #1;
    chk("s2 call count", 32'(count2), 32'h40);
    chk("s2 call sp", 32'(sp2), 32'h1);
    chk("s2 call PC_out", 32'(PC_out2), 32'h40);
    drive(0, 0, 0, 0, 1, 0, 8'h00); @(posedge clk); #1;
    chk("s2 ret count", 32'(count2), 32'h00);
    chk("s2 ret sp", 32'(sp2), 32'h0);

`ifdef PC_REL_BRANCH_EN
    drive(1, 0, 0, 0, 0, 0, 8'h00); @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0, 8'h20); @(posedge clk); #1;
    @(negedge clk); load = 0; branch = 1; offset = 8'hF0;
    @(posedge clk); #1;
    chk("br back count", 32'(count), 32'h10);
    @(negedge clk); en = 1; branch = 1; offset = 8'h05;
    @(posedge clk); #1;
    chk("br over en count", 32'(count), 32'h15);
    @(negedge clk); en = 0; load = 1; PC_in = 8'h77; branch = 1;
    @(posedge clk); #1;
    chk("load over br count", 32'(count), 32'h77);
    @(negedge clk); load = 0; branch = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised program counter for the bus-based CPU datapath; the next generation of the team's 4-bit counter.
- Generalised address width; absolute load from the bus; increment by a configurable stride.
- Adds a hardware return stack for call/return, with sticky overflow and underflow flags.
- Drives the current PC onto the shared bus under output-enable.
- Sits between the control sequencer (op strobes) and the bus/memory-address register.

Parameters:
ADDR_W, 8, PC and bus address width in bits (min 4)
STACK_DEPTH, 4, return-stack entries (power of 2, min 2)
STRIDE, 1, increment amount per count step
RESET_VEC, 0, PC value after reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
en  input  1  count enable: PC <= PC + STRIDE
load  input  1  absolute jump: PC <= PC_in
call  input  1  push PC + STRIDE, then PC <= PC_in
ret  input  1  pop top of stack into PC
OE  input  1  drive PC onto bus
PC_in  input  ADDR_W  target address from bus/programmer
PC_out  output  ADDR_W  bus drive value; PC when OE=1, else all zeros
count  output  ADDR_W  current PC, always valid (registered)
sp  output  clog2(STACK_DEPTH)+1  number of occupied stack entries
ovf  output  1  sticky: call attempted while stack full
unf  output  1  sticky: ret attempted while stack empty
on  output  1  mirrors en combinationally (front-panel LED)

Behaviour:
- Reset is synchronous, active-high, and dominates everything. On reset:
  - count = RESET_VEC; sp = 0; ovf = 0; unf = 0.
  - Stack contents are don't-care.
  - PC_out follows OE.
- Ops are sampled each rising CLK. Priority: load > call > ret > en. Lower-priority strobes in the same cycle are ignored, with no side effects (no push/pop, no flag change).
- Latency: the new PC is visible on count one cycle after the strobe edge. PC_out is combinational from count and OE, with no extra latency.
- Arithmetic:
  - PC + STRIDE is modulo 2^ADDR_W; 2^ADDR_W - STRIDE wraps to 0 with no flag.
  - The pushed return address wraps the same way.
- call:
  - If sp < STACK_DEPTH: stack[sp] <= count + STRIDE, sp <= sp + 1, count <= PC_in.
  - If full: count <= PC_in (the jump still happens), no push, ovf <= 1.
- ret:
  - If sp > 0: count <= stack[sp-1], sp <= sp - 1.
  - If empty: count holds, unf <= 1.
- ovf and unf are cleared only by RESET.
- No op asserted: count holds.
- PC_out = OE ? count : 0. The block never tri-states; bus muxing is external.
- Reset asserted mid-sequence: the call/ret in the same cycle is discarded.

Optional Feature:
Macro: PC_REL_BRANCH_EN
- Defined:
  - Adds input `branch` (1) and input `offset` (ADDR_W, two's complement).
  - Priority: load > call > ret > branch > en.
  - branch: count <= count + offset, modulo 2^ADDR_W. Offset is relative to the current PC, not PC + STRIDE.
- Undefined: the ports are absent and priority is unchanged.

Decomposition:
- Shared package pc_pkg:
  - Op priority encoding as enum {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_BRANCH}.
  - Function clog2.
  - Default constants for ADDR_W and STACK_DEPTH.
- One sub-module: pc_return_stack, a LIFO with push/pop/full/empty/sp and the registered top-of-stack read.
- The top level does op decode, the next-PC mux and the flags.

Test Plan:
- Reset, then en=1 for 5 cycles with ADDR_W=8, STRIDE=1 -> count = 0,1,2,3,4,5; PC_out=0 while OE=0, equals count while OE=1.
- count=0xFE, STRIDE=2, en=1 -> count=0x00 next cycle; ovf=0, unf=0.
- count=0x10, call with PC_in=0x40, then ret -> count=0x40 then 0x11; sp goes 1 then 0.
- Depth 4: five nested calls to 0x80..0x84 -> after the fifth, count=0x84, sp=4, ovf=1; four rets then restore the pushed addresses LIFO.
- ret with sp=0 -> count unchanged, unf=1; holds until RESET, then 0.
- load=1, call=1 and en=1 together with PC_in=0x33 -> count=0x33, sp unchanged. With PC_REL_BRANCH_EN defined: count=0x20, branch offset=0xF0 -> count=0x10.
